// File: rtl/pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_ctrl
// Brief    : Program counter, run/halt sequencer and ALU flag registers.
// Revision : 1.0
// ============================================================================
module pc_ctrl #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stall_i,
    input  logic             halt_i,
    input  logic [3:0]       alu_cmd,
    input  logic [PC_W-1:0]  target,
    input  logic             equal_i,
    input  logic             sc_o_i,
    output logic [PC_W-1:0]  prog_ctr,
    output logic             sc_i,
    output logic             eq_flag,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SHL  = 4'b0001;
    localparam logic [3:0] c_OP_SHR  = 4'b0010;
    localparam logic [3:0] c_OP_ADDI = 4'b0111;
    localparam logic [3:0] c_OP_BNE  = 4'b1000;
    localparam logic [3:0] c_OP_BEQ  = 4'b1001;
    localparam logic [3:0] c_OP_CMP  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_nxt;
    logic [PC_W-1:0]   w_pc_inc;
    logic              r_sc;
    logic              w_sc_nxt;
    logic              r_eq;
    logic              w_eq_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_busy;
    logic              r_done;

    assign w_pc_inc = r_pc + PC_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_sc    <= 1'b0;
            r_eq    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_sc    <= w_sc_nxt;
            r_eq    <= w_eq_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_HALTED);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_sc_nxt    = r_sc;
        w_eq_nxt    = r_eq;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = '0;
                    w_sc_nxt    = 1'b0;
                    w_eq_nxt    = 1'b0;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                if (!stall_i) begin
                    if (halt_i) begin
                        w_state_nxt = S_HALTED;
                    end else begin
                        w_cnt_nxt = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
                        // Branches resolve on the flag latched before this edge.
                        case (alu_cmd)
                            c_OP_BNE: w_pc_nxt = r_eq ? w_pc_inc : target;
                            c_OP_BEQ: w_pc_nxt = r_eq ? target : w_pc_inc;
                            default:  w_pc_nxt = w_pc_inc;
                        endcase
                        if (alu_cmd == c_OP_ADD || alu_cmd == c_OP_SHL ||
                            alu_cmd == c_OP_SHR || alu_cmd == c_OP_ADDI) begin
                            w_sc_nxt = sc_o_i;
                        end
                        if (alu_cmd == c_OP_CMP) begin
                            w_eq_nxt = equal_i;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pc_nxt    = '0;
            end
        endcase
    end

    assign prog_ctr  = r_pc;
    assign sc_i      = r_sc;
    assign eq_flag   = r_eq;
    assign busy      = r_busy;
    assign done      = r_done;
    assign instr_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_ctrl
// Brief    : Table-driven, scoreboarded bench for pc_ctrl (CNT_W=4 to reach saturation).
// Revision : 1.0
// ============================================================================
module tb_pc_ctrl;

    localparam int PC_W  = 10;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic             st;
        logic             sl;
        logic             h;
        logic [3:0]       cmd;
        logic [PC_W-1:0]  tgt;
        logic             eqi;
        logic             sco;
        logic [PC_W-1:0]  pc;
        logic             sc;
        logic             eq;
        logic             b;
        logic             d;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             stall_i = 1'b0;
    logic             halt_i = 1'b0;
    logic [3:0]       alu_cmd = 4'b0011;
    logic [PC_W-1:0]  target = '0;
    logic             equal_i = 1'b0;
    logic             sc_o_i = 1'b0;
    logic [PC_W-1:0]  prog_ctr;
    logic             sc_i;
    logic             eq_flag;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] instr_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    vec_t tbl[$];
    vec_t sb[$];

    pc_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .stall_i   (stall_i),
        .halt_i    (halt_i),
        .alu_cmd   (alu_cmd),
        .target    (target),
        .equal_i   (equal_i),
        .sc_o_i    (sc_o_i),
        .prog_ctr  (prog_ctr),
        .sc_i      (sc_i),
        .eq_flag   (eq_flag),
        .busy      (busy),
        .done      (done),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic sl, input logic h,
                                input logic [3:0] cmd, input int tgt,
                                input logic eqi, input logic sco,
                                input int pc, input logic sc, input logic eq,
                                input logic b, input logic d, input int cnt);
        vec_t v;
        v.st = st; v.sl = sl; v.h = h; v.cmd = cmd; v.tgt = PC_W'(tgt);
        v.eqi = eqi; v.sco = sco; v.pc = PC_W'(pc); v.sc = sc; v.eq = eq;
        v.b = b; v.d = d; v.cnt = CNT_W'(cnt);
        return v;
    endfunction

    task automatic check(input string name, input vec_t e);
        logic [PC_W+CNT_W+3:0] act;
        logic [PC_W+CNT_W+3:0] exp;
        act = {prog_ctr, sc_i, eq_flag, busy, done, instr_cnt};
        exp = {e.pc, e.sc, e.eq, e.b, e.d, e.cnt};
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got pc=%0d sc=%b eq=%b busy=%b done=%b cnt=%0d, want pc=%0d sc=%b eq=%b busy=%b done=%b cnt=%0d",
                      name, prog_ctr, sc_i, eq_flag, busy, done, instr_cnt,
                      e.pc, e.sc, e.eq, e.b, e.d, e.cnt);
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input string name, input vec_t v);
        vec_t e;
        @(negedge clk);
        start = v.st; stall_i = v.sl; halt_i = v.h; alu_cmd = v.cmd;
        target = v.tgt; equal_i = v.eqi; sc_o_i = v.sco;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(name, e);
    endtask

    initial begin
        //              st sl h  cmd      tgt  eqi sco  pc  sc eq b  d  cnt
        tbl.push_back(mk(1, 0, 0, 4'b0011,   0, 0, 0,    0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0011,   0, 0, 0,    1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 4'b0011,   0, 0, 0,    2, 0, 0, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 4'b0011,   0, 0, 0,    3, 0, 0, 1, 0, 3));
        tbl.push_back(mk(1, 0, 0, 4'b0011,   0, 0, 0,    4, 0, 0, 1, 0, 4));
        tbl.push_back(mk(0, 0, 0, 4'b0011,   0, 0, 0,    5, 0, 0, 1, 0, 5));
        tbl.push_back(mk(0, 0, 0, 4'b1101,   0, 1, 0,    6, 0, 1, 1, 0, 6));
        tbl.push_back(mk(0, 0, 0, 4'b1001,  20, 0, 0,   20, 0, 1, 1, 0, 7));
        tbl.push_back(mk(0, 0, 0, 4'b1000,  40, 0, 0,   21, 0, 1, 1, 0, 8));
        tbl.push_back(mk(0, 0, 0, 4'b1101,   0, 0, 0,   22, 0, 0, 1, 0, 9));
        tbl.push_back(mk(0, 0, 0, 4'b1000,  30, 1, 0,   30, 0, 0, 1, 0, 10));
        tbl.push_back(mk(0, 0, 0, 4'b0000,   0, 0, 1,   31, 1, 0, 1, 0, 11));
        tbl.push_back(mk(0, 0, 0, 4'b0101,   0, 0, 0,   32, 1, 0, 1, 0, 12));
        tbl.push_back(mk(0, 0, 0, 4'b0010,   0, 0, 0,   33, 0, 0, 1, 0, 13));
        tbl.push_back(mk(0, 0, 0, 4'b0001,   0, 0, 1,   34, 1, 0, 1, 0, 14));
        tbl.push_back(mk(0, 0, 0, 4'b1101,   0, 1, 0,   35, 1, 1, 1, 0, 15));
        tbl.push_back(mk(1, 1, 1, 4'b1001, 100, 0, 0,   35, 1, 1, 1, 0, 15));
        tbl.push_back(mk(1, 1, 1, 4'b1001, 100, 0, 0,   35, 1, 1, 1, 0, 15));
        tbl.push_back(mk(1, 1, 1, 4'b0000, 100, 0, 0,   35, 1, 1, 1, 0, 15));
        tbl.push_back(mk(0, 0, 0, 4'b0111,   0, 0, 0,   36, 0, 1, 1, 0, 15));
        tbl.push_back(mk(0, 0, 0, 4'b1001,  36, 0, 0,   36, 0, 1, 1, 0, 15));
        tbl.push_back(mk(0, 0, 1, 4'b1001, 100, 0, 1,   36, 0, 1, 0, 1, 15));
        tbl.push_back(mk(0, 0, 0, 4'b0011,   0, 0, 0,   36, 0, 1, 0, 1, 15));
        tbl.push_back(mk(1, 0, 0, 4'b0011,   0, 0, 0,    0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1101,   0, 1, 0,    1, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 4'b1001,1023, 0, 0, 1023, 0, 1, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 4'b0011,   0, 0, 0,    0, 0, 1, 1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 4'b1001,1023, 0, 0, 1023, 0, 1, 1, 0, 4));
        tbl.push_back(mk(0, 0, 1, 4'b1001,   5, 0, 0, 1023, 0, 1, 0, 1, 4));

        #12;
        check("reset_state", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset_n = 1'b1;
        step("idle_no_start", mk(0, 0, 0, 4'b0011, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // Restart from HALTED, set flags, branch to PC 37, then reset mid-cycle.
        step("rs_start", mk(1, 0, 0, 4'b0011,  0, 0, 0,  0, 0, 0, 1, 0, 0));
        step("rs_add",   mk(0, 0, 0, 4'b0000,  0, 0, 1,  1, 1, 0, 1, 0, 1));
        step("rs_cmp",   mk(0, 0, 0, 4'b1101,  0, 1, 0,  2, 1, 1, 1, 0, 2));
        step("rs_beq",   mk(0, 0, 0, 4'b1001, 37, 0, 0, 37, 1, 1, 1, 0, 3));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset_n = 1'b1;
        step("post_reset_idle", mk(0, 0, 0, 4'b0011, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("post_reset_start", mk(1, 0, 0, 4'b0011, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        step("post_reset_first", mk(0, 0, 0, 4'b0011, 0, 0, 0, 1, 0, 0, 1, 0, 1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
